// File: rtl/mul_share_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_rr_arbiter
// Description : Round-robin sharing of one 33x32 multiplier among N_REQ
//               requesters, with a one-entry tagged result register.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_share_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int A_W   = 33,
    parameter int B_W   = 32,
    parameter int P_W   = 64
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*A_W-1:0] req_din0,
    input  logic [N_REQ*B_W-1:0] req_din1,
    output logic [A_W-1:0]       mul_din0,
    output logic [B_W-1:0]       mul_din1,
    input  logic [P_W-1:0]       mul_dout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [P_W-1:0]       rsp_dout
);

    localparam logic [N_REQ-1:0] C_ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    logic            r_rsp_valid_q;
    logic [ID_W-1:0] r_rsp_id_q;
    logic [P_W-1:0]  r_rsp_dout_q;
    logic [ID_W-1:0] r_ptr_q;

    logic            w_rsp_valid_d;
    logic [ID_W-1:0] w_rsp_id_d;
    logic [P_W-1:0]  w_rsp_dout_d;
    logic [ID_W-1:0] w_ptr_d;

    logic            w_can_issue;
    logic            w_grant;
    logic [ID_W-1:0] w_gidx;
    int              w_idx;

    assign w_can_issue = !r_rsp_valid_q || rsp_ready;

    // Search from the pointer upward, wrapping; first valid requester wins.
    always_comb begin
        w_grant = 1'b0;
        w_gidx  = '0;
        w_idx   = 0;
        if (!ap_rst && w_can_issue) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_idx = (int'(r_ptr_q) + k) % N_REQ;
                if (!w_grant && req_valid[w_idx]) begin
                    w_grant = 1'b1;
                    w_gidx  = ID_W'(w_idx);
                end
            end
        end
    end

    assign req_ready = w_grant ? (C_ONE_HOT0 << w_gidx) : '0;
    assign mul_din0  = w_grant ? req_din0[int'(w_gidx)*A_W +: A_W] : '0;
    assign mul_din1  = w_grant ? req_din1[int'(w_gidx)*B_W +: B_W] : '0;

    always_comb begin
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_id_d    = r_rsp_id_q;
        w_rsp_dout_d  = r_rsp_dout_q;
        w_ptr_d       = r_ptr_q;
        if (w_grant) begin
            w_rsp_valid_d = 1'b1;
            w_rsp_id_d    = w_gidx;
            w_rsp_dout_d  = mul_dout;
            w_ptr_d       = ID_W'((int'(w_gidx) + 1) % N_REQ);
        end else if (rsp_ready) begin
            w_rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_rsp_valid_q <= 1'b0;
            r_rsp_id_q    <= '0;
            r_rsp_dout_q  <= '0;
            r_ptr_q       <= '0;
        end else begin
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_id_q    <= w_rsp_id_d;
            r_rsp_dout_q  <= w_rsp_dout_d;
            r_ptr_q       <= w_ptr_d;
        end
    end

    assign rsp_valid = r_rsp_valid_q;
    assign rsp_id    = r_rsp_id_q;
    assign rsp_dout  = r_rsp_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_share_rr_arbiter
// Description : Scoreboard bench for mul_share_rr_arbiter with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_share_rr_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int AW  = 33;
    localparam int BW  = 32;
    localparam int PW  = 64;

    logic            ap_clk = 1'b0;
    logic            ap_rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_din0;
    logic [N*BW-1:0] req_din1;
    logic [AW-1:0]   mul_din0;
    logic [BW-1:0]   mul_din1;
    logic [PW-1:0]   mul_dout;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [PW-1:0]   rsp_dout;
    logic [64:0]     mul_full;

    mul_share_rr_arbiter #(
        .N_REQ(N), .ID_W(IDW), .A_W(AW), .B_W(BW), .P_W(PW)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_din0(req_din0), .req_din1(req_din1),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_dout(rsp_dout)
    );

    always #5 ap_clk = ~ap_clk;

    // Shared combinational multiplier lives outside the arbiter.
    assign mul_full = {32'b0, mul_din0} * {33'b0, mul_din1};
    assign mul_dout = mul_full[63:0];

    typedef struct {
        int          id;
        logic [63:0] p;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [N-1:0]  pend;
    logic [AW-1:0] pa[N];
    logic [BW-1:0] pb[N];
    logic          rr;
    logic          rst;
    int            m_ptr;
    bit            m_busy;
    bit            m_known  = 1'b0;
    bit            m_postrst = 1'b0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [64:0] f;
        f = 65'(a) * 65'(b);
        return f[63:0];
    endfunction

    // One clock cycle: drive inputs, check the model's grant, advance the model.
    task automatic step();
        int g;
        int idx;
        logic [N-1:0] exp_rdy;
        @(negedge ap_clk);
        ap_rst    = rst;
        rsp_ready = rr;
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_din0[i*AW +: AW] = pa[i];
            req_din1[i*BW +: BW] = pb[i];
        end
        #1;
        g = -1;
        if (!rst && (!m_busy || rr)) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && pend[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 65'(req_ready), 65'(exp_rdy));
        if (g >= 0) begin
            chk("mul_din0", 65'(mul_din0), 65'(pa[g]));
            chk("mul_din1", 65'(mul_din1), 65'(pb[g]));
        end else begin
            chk("mul_quiet", {mul_din0, mul_din1}, 65'd0);
        end
        if (m_known) chk("rsp_valid", 65'(rsp_valid), 65'(m_busy));
        if (m_postrst) begin
            chk("rst_id", 65'(rsp_id), 65'd0);
            chk("rst_dout", 65'(rsp_dout), 65'd0);
        end
        m_postrst = 1'b0;
        if (rst) begin
            m_busy    = 1'b0;
            m_ptr     = 0;
            sb.delete();
            m_known   = 1'b1;
            m_postrst = 1'b1;
        end else if (g >= 0) begin
            sb.push_back('{id: g, p: prod(pa[g], pb[g])});
            pend[g] = 1'b0;
            m_busy  = 1'b1;
            m_ptr   = (g + 1) % N;
        end else if (rr) begin
            m_busy = 1'b0;
        end
    endtask

    // Monitor: compares the presented result with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge ap_clk);
            #2;
            if (!ap_rst && m_known && rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 65'd1, 65'd0);
                end else begin
                    e = sb[0];
                    chk("rsp_id", 65'(rsp_id), 65'(e.id));
                    chk("rsp_dout", 65'(rsp_dout), 65'(e.p));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        ap_rst = 1'b1; rsp_ready = 1'b0; req_valid = '0; req_din0 = '0; req_din1 = '0;
        pend = '0; rr = 1'b1; rst = 1'b0; m_ptr = 0; m_busy = 1'b0;
        for (int i = 0; i < N; i++) begin pa[i] = '0; pb[i] = '0; end

        // Reset, then a single request from requester 2.
        do_reset();
        pend[2] = 1'b1; pa[2] = 33'd3; pb[2] = 32'd5;
        step();
        step();
        chk("t1_id", 65'(rsp_id), 65'd2);
        chk("t1_dout", 65'(rsp_dout), 65'd15);

        // All four requesters continuously valid.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < N; i++) begin
                pend[i] = (k < 8); pa[i] = AW'(i + 1); pb[i] = 32'd10;
            end
            step();
            if (k >= 1) begin
                chk("rr_id", 65'(rsp_id), 65'((k - 1) % 4));
                chk("rr_dout", 65'(rsp_dout), 65'((((k - 1) % 4) + 1) * 10));
            end
        end

        // Backpressure with requester 1 waiting.
        pend = 4'b0010; pa[1] = 33'd7; pb[1] = 32'd9;
        rr = 1'b1; step();
        rr = 1'b0;
        pend[1] = 1'b1;
        for (int k = 0; k < 3; k++) step();
        rr = 1'b1; step();
        step();
        chk("bp_id", 65'(rsp_id), 65'd1);
        chk("bp_dout", 65'(rsp_dout), 65'd63);

        // Width boundaries.
        pend[0] = 1'b1; pa[0] = {AW{1'b1}}; pb[0] = {BW{1'b1}};
        step();
        pend[2] = 1'b1; pa[2] = '0; pb[2] = {BW{1'b1}};
        step();
        chk("wmax_dout", 65'(rsp_dout), 65'h0_FFFF_FFFD_0000_0001);
        step();
        chk("wzero_dout", 65'(rsp_dout), 65'd0);

        // Pointer wrap and skip.
        do_reset();
        pend = 4'b0100; step();
        pend = 4'b0010; step();
        pend = 4'b1011;
        for (int k = 0; k < 4; k++) step();

        // Reset while busy with requests pending.
        pend = 4'b1111; rr = 1'b0; step(); step();
        do_reset();
        step();
        pend = '0; rr = 1'b1;
        step(); step(); step(); step();

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            rr = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 2) == 1) begin
                    pend[i] = 1'b1;
                    pa[i]   = {1'($urandom % 2), 32'($urandom)};
                    pb[i]   = 32'($urandom);
                end
            end
            step();
        end

        pend = '0; rr = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("sb_empty", 65'(sb.size()), 65'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
